// File: rtl/prior_enc_pkg.sv
// prior_enc_pkg: shared constants, state encoding and helpers for the
// sequential priority encoder slice (prior_encoder_seq and friends).
package prior_enc_pkg;

   // Default number of request inputs.
   localparam int unsigned DEFAULT_N = 8;

   // Widest vector the onehot helper can produce; callers cast down to N bits.
   localparam int unsigned MAX_N = 256;

   // Presenter state; the state bit doubles as out_valid.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   // One-hot mask with bit idx set, or all-zero when idx is out of range.
   function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
      logic [MAX_N-1:0] m;
      m = '0;
      if (idx < n && idx < MAX_N) m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/prior_encoder_seq_if.sv
// prior_encoder_seq_if: request/handshake bundle of prior_encoder_seq.
//   req_in, req_load : request vector and load strobe (master -> slave)
//   out_ack          : consumer accept (master -> slave)
//   out_idx, out_valid, pending, none : encoder outputs (slave -> master)
import prior_enc_pkg::*;

interface prior_encoder_seq_if #(
   parameter int unsigned N = DEFAULT_N
);
   localparam int unsigned W = $clog2(N);

   logic [N-1:0] req_in;
   logic         req_load;
   logic [W-1:0] out_idx;
   logic         out_valid;
   logic         out_ack;
   logic [N-1:0] pending;
   logic         none;

   modport master (
      output req_in, req_load, out_ack,
      input  out_idx, out_valid, pending, none
   );

   modport slave (
      input  req_in, req_load, out_ack,
      output out_idx, out_valid, pending, none
   );
endinterface

// File: rtl/prior_encoder_comb.sv
// prior_encoder_comb: combinational N-to-W priority encoder.
//   vec   : request vector
//   start : highest-priority position; search walks downward from here,
//           wrapping N-1 -> 0 (tie to N-1 for plain MSB-first priority)
//   idx   : first set position found (0 when vec is empty)
//   any   : vec has at least one bit set
import prior_enc_pkg::*;

module prior_encoder_comb #(
   parameter int unsigned N = DEFAULT_N,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         any
);

   // Scan from the furthest offset to the nearest so the nearest hit wins.
   always_comb begin
      int p;
      idx = '0;
      p   = 0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         p = int'(start) - k;
         if (p < 0) p = p + int'(N);
         if (vec[W'(p)]) idx = W'(p);
      end
   end

   assign any = |vec;

endmodule

// File: rtl/prior_encoder_seq.sv
// prior_encoder_seq: registered N-input priority encoder with a pending
// request store and a valid/ack output handshake.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : prior_encoder_seq_if.slave (req_in, req_load, out_ack in;
//           out_idx, out_valid, pending, none out, all outputs registered)
// Build option: define ROUND_ROBIN_EN for rotating priority (the served
// source becomes lowest priority); default is fixed MSB-first priority.
import prior_enc_pkg::*;

module prior_encoder_seq #(
   parameter int unsigned N = DEFAULT_N
) (
   input  logic                      clk,
   input  logic                      reset,
   prior_encoder_seq_if.slave        bus
);

   localparam int unsigned W = $clog2(N);

   state_t       state;
   logic [W-1:0] out_idx_q;
   logic [N-1:0] pending_q;
   logic         none_q;

   logic [N-1:0] served;
   logic [N-1:0] pend_next;
   logic [W-1:0] prio_idx;
   logic         any_next;
   logic [W-1:0] start;
   logic         ack_fire;

   assign ack_fire = (state == ST_PRESENT) && bus.out_ack;

   // Next pending value: clear the acknowledged bit, new requests win over the clear.
   always_comb begin
      served = '0;
      if (ack_fire) served = N'(onehot(32'(out_idx_q), N));
      pend_next = (pending_q & ~served) | (bus.req_load ? bus.req_in : '0);
   end

`ifdef ROUND_ROBIN_EN
   logic [W-1:0] rr_ptr;

   // Rotating pointer: after serving k, search starts just below k.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= W'(N - 1);
      end else if (ack_fire) begin
         rr_ptr <= (out_idx_q == '0) ? W'(N - 1) : out_idx_q - W'(1);
      end
   end

   assign start = rr_ptr;
`else
   assign start = W'(N - 1);
`endif

   prior_encoder_comb #(.N(N)) u_enc (
      .vec   (pend_next),
      .start (start),
      .idx   (prio_idx),
      .any   (any_next)
   );

   // Presenter FSM: the index is latched on entry or after each ack and held while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         out_idx_q <= '0;
         pending_q <= '0;
         none_q    <= 1'b1;
      end else begin
         pending_q <= pend_next;
         none_q    <= ~any_next;
         case (state)
            ST_IDLE: begin
               if (any_next) begin
                  out_idx_q <= prio_idx;
                  state     <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (bus.out_ack) begin
                  if (any_next) out_idx_q <= prio_idx;
                  else          state     <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.out_idx   = out_idx_q;
   assign bus.out_valid = (state == ST_PRESENT);
   assign bus.pending   = pending_q;
   assign bus.none      = none_q;

endmodule

// File: tb/tb_prior_encoder_seq.sv
// tb_prior_encoder_seq: randomized and directed checks of prior_encoder_seq
// against a behavioural model of the request store and handshake.
import prior_enc_pkg::*;

module tb_prior_encoder_seq;

   localparam int unsigned N = 8;
   localparam int unsigned W = $clog2(N);

   logic clk = 1'b0;
   logic reset;

   int checks = 0;
   int errors = 0;

   prior_encoder_seq_if #(.N(N)) bus ();

   prior_encoder_seq #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model state
   logic [N-1:0] m_pend;
   bit           m_valid;
   int           m_idx;
   int           m_rr;

   // Selection rule: fixed = highest set bit; rotating = first set bit walking down from rr.
   function automatic int m_prio(input logic [N-1:0] v, input int rr);
      int sel;
      sel = 0;
`ifdef ROUND_ROBIN_EN
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (v[(rr - k + int'(N)) % int'(N)]) sel = (rr - k + int'(N)) % int'(N);
      end
`else
      sel = rr - rr;
      for (int i = 0; i < int'(N); i++) if (v[i]) sel = i;
`endif
      return sel;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, compare outputs.
   task automatic cycle(input bit rst, input bit ld, input logic [N-1:0] v, input bit ack);
      logic [N-1:0] pn;
      int           p;
      reset        = rst;
      bus.req_load = ld;
      bus.req_in   = v;
      bus.out_ack  = ack;
      @(posedge clk);
      if (rst) begin
         m_pend  = '0;
         m_valid = 0;
         m_idx   = 0;
         m_rr    = int'(N) - 1;
      end else begin
         pn = m_pend;
         if (m_valid && ack) pn[m_idx] = 1'b0;
         if (ld) pn = pn | v;
         p = m_prio(pn, m_rr);
         if (m_valid && ack) m_rr = (m_idx == 0) ? int'(N) - 1 : m_idx - 1;
         if (!m_valid) begin
            if (pn != 0) begin
               m_idx   = p;
               m_valid = 1;
            end
         end else if (ack) begin
            if (pn != 0) m_idx = p;
            else         m_valid = 0;
         end
         m_pend = pn;
      end
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("pending",   32'(bus.pending),   32'(m_pend));
      check("none",      32'(bus.none),      32'(m_pend == '0));
      if (m_valid || rst) check("out_idx", 32'(bus.out_idx), 32'(m_idx));
   endtask

   initial begin
      m_pend  = '0;
      m_valid = 0;
      m_idx   = 0;
      m_rr    = int'(N) - 1;

      // Reset held with a full load pending; release.
      cycle(1, 1, '1, 0);
      cycle(1, 1, '1, 0);
      cycle(0, 0, '0, 0);
      cycle(0, 0, '0, 1);

      // Single requests, one at a time, each acknowledged.
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, N'(1 << i), 0);
         cycle(0, 0, '0, 1);
         cycle(0, 0, '0, 0);
      end

      // Priority drain with ack held high.
      cycle(0, 1, N'(8'b0101), 1);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);
      cycle(0, 1, N'(8'b1100), 1);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);

      // Stall: higher request arrives mid-stall without preempting.
      cycle(0, 1, N'(8'b0001), 0);
      cycle(0, 0, '0, 0);
      cycle(0, 1, N'(8'b1000), 0);
      cycle(0, 0, '0, 0);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);

      // Re-request of the bit being acknowledged keeps it pending.
      cycle(0, 1, N'(8'b0100), 0);
      cycle(0, 1, N'(8'b0100), 1);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);

      // Full vector drains in N acked cycles; then reload and a sparse vector.
      cycle(0, 1, '1, 0);
      for (int i = 0; i < int'(N) + 1; i++) cycle(0, 0, '0, 1);
      cycle(0, 1, '1, 0);
      for (int i = 0; i < int'(N) + 1; i++) cycle(0, 0, '0, 1);
      cycle(0, 1, N'(8'b1000), 0);
      cycle(0, 0, '0, 1);
      cycle(0, 1, N'(8'b1010), 0);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);

      // Empty load is a no-op; reset mid-operation drops everything.
      cycle(0, 1, '0, 0);
      cycle(0, 1, N'(8'b0110_0011), 0);
      cycle(1, 0, '0, 0);
      cycle(0, 0, '0, 1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bit          r;
         bit          ld;
         bit          ak;
         logic [N-1:0] v;
         r  = ($urandom_range(0, 199) == 0);
         ld = ($urandom_range(0, 9) < 3);
         ak = ($urandom_range(0, 9) < 6);
         v  = N'($urandom);
         if ($urandom_range(0, 3) == 0) v = N'(1 << $urandom_range(0, N - 1));
         cycle(r, ld, v, ak);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
